shared_bank_alloc: RTL and testbench
====================================

SHARED_BANK_ALLOC -- requirements
Module: shared_bank_alloc

Interface
REQ-001 SHALL have parameter num_ports, default 5: number of requesting router ports.
REQ-002 SHALL have parameter num_banks, default 6: number of shared memory banks.
REQ-003 SHALL have parameter bank_depth, default 8: flit capacity per bank.
REQ-004 SHALL have parameter reset_type, default `RESET_TYPE_ASYNC: reset style selector.
REQ-005 SHALL define bank_idx_width = clogb(num_banks) and cnt_width = clogb(bank_depth+1).
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port req_port, input, num_ports: per-port request for a shared bank.
REQ-009 SHALL have port push_port, input, num_ports: per-port write of one flit into that port's owned bank.
REQ-010 SHALL have port release_port, input, num_ports: per-port tail-sent pulse that ends ownership.
REQ-011 SHALL have port pop_valid, input, 1: one flit consumed from a bank.
REQ-012 SHALL have port pop_bank, input, bank_idx_width: bank index for pop_valid.
REQ-013 SHALL have port memory_bank_grant, output, num_ports: one-hot, one-cycle grant pulse.
REQ-014 SHALL have port gnt_bank, output, bank_idx_width: bank index valid with memory_bank_grant.
REQ-015 SHALL have port owns_bank, output, num_ports: level; port currently owns a bank.
REQ-016 SHALL have port credit_for_shared, output, 1: one-cycle pulse when a bank returns to FREE.
REQ-017 SHALL have port free_banks, output, clogb(num_banks+1): count of FREE banks.
REQ-018 SHALL have port error, output, 1: sticky protocol-violation flag.

Function
REQ-019 SHALL keep per bank: state FREE/OWNED/DRAINING, owner index, occupancy counter (cnt_width).
REQ-020 SHALL consider port p eligible when req_port[p]=1 and owns_bank[p]=0.
REQ-021 SHALL grant at most one port per cycle, round-robin: after granting p, priority starts at (p+1) mod num_ports; pointer unchanged without grant.
REQ-022 SHALL assign the lowest-indexed FREE bank; no grant when free_banks=0.
REQ-023 SHALL register grant: eligible request at cycle t -> memory_bank_grant/gnt_bank at t+1; bank enters OWNED and owns_bank[p]=1 at t+1.
REQ-024 SHALL treat requests held after grant as ignored (port masked while owning).
REQ-025 SHALL increment occupancy on push_port[p] to p's OWNED bank, decrement on pop to that bank; simultaneous push and pop leave it unchanged.
REQ-026 SHALL on release_port[p]: OWNED -> DRAINING, owns_bank[p]=0 next cycle; push in the same cycle still counts.
REQ-027 SHALL on DRAINING with occupancy reaching 0 (or already 0 at release): -> FREE next cycle, credit_for_shared=1 for exactly that cycle.
REQ-028 SHALL make a bank freed at cycle t allocatable only by requests evaluated at t+1 or later.
REQ-029 SHALL assert credit_for_shared once per freeing cycle even if multiple banks free simultaneously (coincident frees are counted in free_banks).
REQ-030 SHALL set error and drop the operation on: push at occupancy=bank_depth; push from port owning no bank; pop to FREE bank or occupancy 0; release from non-owning port.
REQ-031 SHALL never let occupancy wrap below 0 or above bank_depth.

Reset
REQ-032 SHALL on reset: all banks FREE, occupancy 0, RR pointer at port 0, memory_bank_grant=0, gnt_bank=0, owns_bank=0, credit_for_shared=0, free_banks=num_banks, error=0.
REQ-033 SHALL abandon in-flight ownership on reset assertion mid-operation; no credit pulse emitted for abandoned banks.

Verification
REQ-034 SHALL cover: reset, req_port=5'b00100 at t -> memory_bank_grant=5'b00100, gnt_bank=0 at t+1, free_banks=5.
REQ-035 SHALL cover: req_port=5'b11111 held from reset -> grants ports 0,1,2,3,4 on consecutive cycles, gnt_bank 0..4, free_banks=1.
REQ-036 SHALL cover: 7 ports' worth of requests with num_banks=6 exhausted -> no grant until a bank frees; grant appears one cycle after credit_for_shared.
REQ-037 SHALL cover: port 0 pushes 8 flits, 9th push -> error=1, occupancy stays 8.
REQ-038 SHALL cover: port 1 pushes 3, releases, 3 pops to bank 0 -> credit_for_shared pulse cycle after third pop, free_banks back to 6.
REQ-039 SHALL cover: push and pop same bank same cycle at occupancy 8 -> occupancy 8, error=0.

Source files
------------

// File: rtl/shared_bank_alloc.sv
// ---------------------------------------------------------------------------
// shared_bank_alloc
//
// Hands out shared memory banks to router ports. A port that requests a bank
// while owning none gets a grant, round-robin across ports. The bank it gets
// is the lowest-indexed FREE bank. The port then pushes flits into its bank.
// A consumer pops flits from any non-empty bank by index. When the port sends
// its tail (release), the bank drains. When its occupancy reaches zero the
// bank returns to FREE, and a one-cycle credit pulse is emitted.
//
// Ports:
//   clk               - single clock; all state updates on its rising edge
//   reset             - active-high reset (asynchronous by default)
//   req_port          - per-port request for a shared bank
//   push_port         - per-port write of one flit into the port's owned bank
//   release_port      - per-port tail-sent pulse that ends ownership
//   pop_valid         - one flit consumed from bank pop_bank
//   pop_bank          - bank index qualified by pop_valid
//   memory_bank_grant - one-hot grant pulse (one cycle)
//   gnt_bank          - bank index qualified by memory_bank_grant
//   owns_bank         - per-port level: port currently owns a bank
//   credit_for_shared - one-cycle pulse in any cycle a bank became FREE
//   free_banks        - number of FREE banks
//   error             - sticky protocol-violation flag
// ---------------------------------------------------------------------------

`ifndef RESET_TYPE_ASYNC
`define RESET_TYPE_ASYNC 0
`endif
`ifndef RESET_TYPE_SYNC
`define RESET_TYPE_SYNC 1
`endif

package shared_bank_alloc_pkg;

  typedef enum logic [1:0] {
    BANK_FREE     = 2'b00,
    BANK_OWNED    = 2'b01,
    BANK_DRAINING = 2'b10
  } bank_state_e;

  // Index width for 'value' distinct items, never less than one bit.
  function automatic int clogb(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

module shared_bank_alloc
  import shared_bank_alloc_pkg::*;
#(
  parameter int num_ports  = 5,
  parameter int num_banks  = 6,
  parameter int bank_depth = 8,
  parameter int reset_type = `RESET_TYPE_ASYNC,
  localparam int bank_idx_width = clogb(num_banks),
  localparam int cnt_width      = clogb(bank_depth + 1),
  localparam int free_width     = clogb(num_banks + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [num_ports-1:0]      req_port,
  input  logic [num_ports-1:0]      push_port,
  input  logic [num_ports-1:0]      release_port,
  input  logic                      pop_valid,
  input  logic [bank_idx_width-1:0] pop_bank,
  output logic [num_ports-1:0]      memory_bank_grant,
  output logic [bank_idx_width-1:0] gnt_bank,
  output logic [num_ports-1:0]      owns_bank,
  output logic                      credit_for_shared,
  output logic [free_width-1:0]     free_banks,
  output logic                      error
);

  localparam int port_idx_width = clogb(num_ports);

  typedef struct packed {
    bank_state_e               state;
    logic [port_idx_width-1:0] owner;
    logic [cnt_width-1:0]      occ;
  } bank_t;

  // Every piece of state, including the registered outputs, lives in one
  // record, so both reset flavours share a single next-state computation.
  typedef struct packed {
    bank_t [num_banks-1:0]     banks;
    logic [port_idx_width-1:0] rr_ptr;
    logic [num_ports-1:0]      grant;
    logic [bank_idx_width-1:0] gnt_bank;
    logic [num_ports-1:0]      owns;
    logic                      credit;
    logic [free_width-1:0]     free_cnt;
    logic                      error;
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;

  bank_t [num_banks-1:0]     banks_upd_s;
  logic                      bank_viol_s;
  logic                      freed_s;
  logic                      push_hit_s;
  logic                      pop_hit_s;
  logic                      rel_hit_s;
  logic                      push_ok_s;
  logic                      pop_ok_s;
  logic [cnt_width-1:0]      occ_new_s;

  logic                      port_viol_s;

  logic [num_ports-1:0]      eligible_s;
  int                        rr_idx_s;
  logic [port_idx_width-1:0] rr_sel_s;
  logic                      port_found_s;
  logic                      free_avail_s;
  logic                      gnt_valid_s;
  logic [port_idx_width-1:0] gnt_port_s;
  logic [bank_idx_width-1:0] gnt_bank_s;

  logic [num_ports-1:0]      owns_s;
  logic [free_width-1:0]     free_s;

  // Per-bank occupancy and FREE/OWNED/DRAINING transitions from push/pop/release
  always_comb begin
    banks_upd_s = state_r.banks;
    bank_viol_s = 1'b0;
    freed_s     = 1'b0;
    push_hit_s  = 1'b0;
    pop_hit_s   = 1'b0;
    rel_hit_s   = 1'b0;
    push_ok_s   = 1'b0;
    pop_ok_s    = 1'b0;
    occ_new_s   = {cnt_width{1'b0}};
    for (int b = 0; b < num_banks; b++) begin
      // Only an OWNED bank has a live owner; its push/release lines route here.
      pop_hit_s  = pop_valid && (int'(pop_bank) == b);
      push_hit_s = (state_r.banks[b].state == BANK_OWNED) && push_port[state_r.banks[b].owner];
      rel_hit_s  = (state_r.banks[b].state == BANK_OWNED) && release_port[state_r.banks[b].owner];
      pop_ok_s   = pop_hit_s && (state_r.banks[b].state != BANK_FREE) &&
                   (state_r.banks[b].occ != {cnt_width{1'b0}});
      // A full bank still accepts a push when a legal pop frees a slot this cycle.
      push_ok_s  = push_hit_s &&
                   ((state_r.banks[b].occ != cnt_width'(bank_depth)) || pop_ok_s);
      bank_viol_s = bank_viol_s | (pop_hit_s & ~pop_ok_s) | (push_hit_s & ~push_ok_s);

      case ({push_ok_s, pop_ok_s})
        2'b10:   occ_new_s = state_r.banks[b].occ + cnt_width'(1);
        2'b01:   occ_new_s = state_r.banks[b].occ - cnt_width'(1);
        default: occ_new_s = state_r.banks[b].occ;
      endcase
      banks_upd_s[b].occ = occ_new_s;

      case (state_r.banks[b].state)
        BANK_OWNED: begin
          if (rel_hit_s && (occ_new_s == {cnt_width{1'b0}})) begin
            banks_upd_s[b].state = BANK_FREE;
            freed_s              = 1'b1;
          end else if (rel_hit_s) begin
            banks_upd_s[b].state = BANK_DRAINING;
          end else begin
            banks_upd_s[b].state = BANK_OWNED;
          end
        end
        BANK_DRAINING: begin
          if (occ_new_s == {cnt_width{1'b0}}) begin
            banks_upd_s[b].state = BANK_FREE;
            freed_s              = 1'b1;
          end else begin
            banks_upd_s[b].state = BANK_DRAINING;
          end
        end
        BANK_FREE: begin
          banks_upd_s[b].state = BANK_FREE;
        end
        default: begin
          // Unused encoding: fall back to an empty FREE bank.
          banks_upd_s[b].state = BANK_FREE;
          banks_upd_s[b].occ   = {cnt_width{1'b0}};
        end
      endcase
    end
  end

  // Port-side violations: push or release from a port that owns no bank, pop index out of range
  always_comb begin
    port_viol_s = (|((push_port | release_port) & ~state_r.owns)) |
                  (pop_valid & (int'(pop_bank) >= num_banks));
  end

  // Round-robin port selection and lowest-index FREE bank selection on current state
  always_comb begin
    eligible_s   = req_port & ~state_r.owns;
    rr_idx_s     = 0;
    rr_sel_s     = {port_idx_width{1'b0}};
    port_found_s = 1'b0;
    free_avail_s = 1'b0;
    gnt_port_s   = {port_idx_width{1'b0}};
    gnt_bank_s   = {bank_idx_width{1'b0}};
    // Scanning downwards lets the last hit, i.e. the lowest index, win.
    for (int b = num_banks - 1; b >= 0; b--) begin
      gnt_bank_s   = (state_r.banks[b].state == BANK_FREE) ? bank_idx_width'(b) : gnt_bank_s;
      free_avail_s = free_avail_s | (state_r.banks[b].state == BANK_FREE);
    end
    // Same trick for ports: offset 0 from the pointer has highest priority.
    for (int i = num_ports - 1; i >= 0; i--) begin
      rr_idx_s     = int'(state_r.rr_ptr) + i;
      rr_idx_s     = (rr_idx_s >= num_ports) ? (rr_idx_s - num_ports) : rr_idx_s;
      rr_sel_s     = port_idx_width'(rr_idx_s);
      gnt_port_s   = eligible_s[rr_sel_s] ? rr_sel_s : gnt_port_s;
      port_found_s = port_found_s | eligible_s[rr_sel_s];
    end
    gnt_valid_s = port_found_s & free_avail_s;
  end

  // Next-state assembly: apply the grant, then derive ownership and free count from the result
  always_comb begin
    state_nxt_s       = state_r;
    state_nxt_s.banks = banks_upd_s;
    owns_s            = {num_ports{1'b0}};
    free_s            = {free_width{1'b0}};
    if (gnt_valid_s) begin
      state_nxt_s.banks[gnt_bank_s].state = BANK_OWNED;
      state_nxt_s.banks[gnt_bank_s].owner = gnt_port_s;
      state_nxt_s.banks[gnt_bank_s].occ   = {cnt_width{1'b0}};
      state_nxt_s.rr_ptr   = (int'(gnt_port_s) == num_ports - 1) ?
                             {port_idx_width{1'b0}} : (gnt_port_s + port_idx_width'(1));
      state_nxt_s.grant    = num_ports'(1) << gnt_port_s;
      state_nxt_s.gnt_bank = gnt_bank_s;
    end else begin
      state_nxt_s.rr_ptr   = state_r.rr_ptr;
      state_nxt_s.grant    = {num_ports{1'b0}};
      state_nxt_s.gnt_bank = {bank_idx_width{1'b0}};
    end
    for (int b = 0; b < num_banks; b++) begin
      owns_s[state_nxt_s.banks[b].owner] = owns_s[state_nxt_s.banks[b].owner] |
                                           (state_nxt_s.banks[b].state == BANK_OWNED);
      free_s = free_s + ((state_nxt_s.banks[b].state == BANK_FREE) ?
                         free_width'(1) : free_width'(0));
    end
    state_nxt_s.owns     = owns_s;
    state_nxt_s.free_cnt = free_s;
    state_nxt_s.credit   = freed_s;
    state_nxt_s.error    = state_r.error | bank_viol_s | port_viol_s;
  end

  generate
    if (reset_type == `RESET_TYPE_SYNC) begin : g_sync_reset
      // State register, synchronous reset flavour
      always_ff @(posedge clk) begin
        if (reset) begin
          state_r          <= '0;
          state_r.free_cnt <= free_width'(num_banks);
        end else begin
          state_r <= state_nxt_s;
        end
      end
    end else begin : g_async_reset
      // State register, asynchronous reset flavour; reset abandons all ownership silently
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_r          <= '0;
          state_r.free_cnt <= free_width'(num_banks);
        end else begin
          state_r <= state_nxt_s;
        end
      end
    end
  endgenerate

  assign memory_bank_grant = state_r.grant;
  assign gnt_bank          = state_r.gnt_bank;
  assign owns_bank         = state_r.owns;
  assign credit_for_shared = state_r.credit;
  assign free_banks        = state_r.free_cnt;
  assign error             = state_r.error;

endmodule

// File: tb/tb_shared_bank_alloc.sv
// ---------------------------------------------------------------------------
// tb_shared_bank_alloc
//
// Directed bench for shared_bank_alloc with its defaults: 5 ports, 6 banks,
// depth 8. Inputs change 1 time unit after a rising edge. Outputs are sampled
// at that same point, so each check sees the registered response to the
// inputs applied in the previous cycle.
// ---------------------------------------------------------------------------
module tb_shared_bank_alloc;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req_port;
  logic [4:0] push_port;
  logic [4:0] release_port;
  logic       pop_valid;
  logic [2:0] pop_bank;
  logic [4:0] memory_bank_grant;
  logic [2:0] gnt_bank;
  logic [4:0] owns_bank;
  logic       credit_for_shared;
  logic [2:0] free_banks;
  logic       error;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shared_bank_alloc dut (
    .clk               (clk),
    .reset             (reset),
    .req_port          (req_port),
    .push_port         (push_port),
    .release_port      (release_port),
    .pop_valid         (pop_valid),
    .pop_bank          (pop_bank),
    .memory_bank_grant (memory_bank_grant),
    .gnt_bank          (gnt_bank),
    .owns_bank         (owns_bank),
    .credit_for_shared (credit_for_shared),
    .free_banks        (free_banks),
    .error             (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] g, input logic [2:0] gb,
                         input logic [4:0] ow, input logic cr, input logic [2:0] fb,
                         input logic er);
    chk({tag, "/grant"},  32'(memory_bank_grant), 32'(g));
    chk({tag, "/gnt"},    32'(gnt_bank),          32'(gb));
    chk({tag, "/owns"},   32'(owns_bank),         32'(ow));
    chk({tag, "/credit"}, 32'(credit_for_shared), 32'(cr));
    chk({tag, "/free"},   32'(free_banks),        32'(fb));
    chk({tag, "/error"},  32'(error),             32'(er));
  endtask

  task automatic clear_inputs();
    req_port     = 5'b00000;
    push_port    = 5'b00000;
    release_port = 5'b00000;
    pop_valid    = 1'b0;
    pop_bank     = 3'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values, then a single request from port 2.
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk_out("reset", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b0);
    reset    = 1'b0;
    req_port = 5'b00100;
    tick();
    chk_out("single", 5'b00100, 3'd0, 5'b00100, 1'b0, 3'd5, 1'b0);
    req_port = 5'b00000;
    tick();
    chk_out("single_hold", 5'b00000, 3'd0, 5'b00100, 1'b0, 3'd5, 1'b0);

    // Reset asserted between edges drops ownership at once, with no credit.
    reset = 1'b1;
    #2;
    chk_out("async_rst", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk_out("post_rst", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b0);

    // All ports request from reset: consecutive round-robin grants.
    reset    = 1'b1;
    req_port = 5'b11111;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 5'(1 << i), 3'(i), 5'((1 << (i + 1)) - 1),
              1'b0, 3'(5 - i), 1'b0);
    end
    tick();
    chk_out("rr_idle", 5'b00000, 3'd0, 5'b11111, 1'b0, 3'd1, 1'b0);

    // Exhaustion: port 0 re-requests and takes the last bank.
    // Port 1 then starves until bank 0 drains.
    push_port = 5'b00001;
    tick();
    chk_out("x_push", 5'b00000, 3'd0, 5'b11111, 1'b0, 3'd1, 1'b0);
    push_port    = 5'b00000;
    release_port = 5'b00001;
    tick();
    chk_out("x_rel0", 5'b00000, 3'd0, 5'b11110, 1'b0, 3'd1, 1'b0);
    release_port = 5'b00000;
    tick();
    chk_out("x_regrant", 5'b00001, 3'd5, 5'b11111, 1'b0, 3'd0, 1'b0);
    push_port    = 5'b00010;
    release_port = 5'b00010;
    tick();
    chk_out("x_rel1", 5'b00000, 3'd0, 5'b11101, 1'b0, 3'd0, 1'b0);
    push_port    = 5'b00000;
    release_port = 5'b00000;
    tick();
    chk_out("x_starved", 5'b00000, 3'd0, 5'b11101, 1'b0, 3'd0, 1'b0);
    tick();
    chk_out("x_starved2", 5'b00000, 3'd0, 5'b11101, 1'b0, 3'd0, 1'b0);
    pop_valid = 1'b1;
    pop_bank  = 3'd0;
    tick();
    chk_out("x_credit", 5'b00000, 3'd0, 5'b11101, 1'b1, 3'd1, 1'b0);
    pop_valid = 1'b0;
    tick();
    chk_out("x_late_grant", 5'b00010, 3'd0, 5'b11111, 1'b0, 3'd0, 1'b0);

    // Fill bank 0 to depth. Then push and pop together at full.
    // Then a lone push at full overflows.
    do_reset();
    chk_out("rst2", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b0);
    req_port = 5'b00001;
    tick();
    chk_out("p0_grant", 5'b00001, 3'd0, 5'b00001, 1'b0, 3'd5, 1'b0);
    req_port  = 5'b00000;
    push_port = 5'b00001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fill%0d/error", i), 32'(error), 32'd0);
    end
    pop_valid = 1'b1;
    pop_bank  = 3'd0;
    tick();
    chk("pushpop_full/error", 32'(error), 32'd0);
    pop_valid = 1'b0;
    tick();
    chk("overflow/error", 32'(error), 32'd1);
    push_port    = 5'b00000;
    release_port = 5'b00001;
    tick();
    chk_out("full_rel", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd5, 1'b1);
    release_port = 5'b00000;
    pop_valid    = 1'b1;
    pop_bank     = 3'd0;
    // Exactly eight pops drain it: occupancy stayed at 8.
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("drain%0d/credit", i), 32'(credit_for_shared), 32'd0);
    end
    tick();
    chk_out("drain8", 5'b00000, 3'd0, 5'b00000, 1'b1, 3'd6, 1'b1);
    pop_valid = 1'b0;
    tick();
    chk_out("drain_after", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b1);

    // Port 1 pushes 3, releases, and three pops bring the credit.
    do_reset();
    req_port = 5'b00010;
    tick();
    chk_out("p1_grant", 5'b00010, 3'd0, 5'b00010, 1'b0, 3'd5, 1'b0);
    req_port  = 5'b00000;
    push_port = 5'b00010;
    tick();
    tick();
    tick();
    push_port    = 5'b00000;
    release_port = 5'b00010;
    tick();
    chk_out("p1_rel", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd5, 1'b0);
    release_port = 5'b00000;
    pop_valid    = 1'b1;
    pop_bank     = 3'd0;
    tick();
    chk("p1_pop1/credit", 32'(credit_for_shared), 32'd0);
    tick();
    chk("p1_pop2/credit", 32'(credit_for_shared), 32'd0);
    tick();
    chk_out("p1_credit", 5'b00000, 3'd0, 5'b00000, 1'b1, 3'd6, 1'b0);
    pop_valid = 1'b0;
    tick();
    chk_out("p1_after", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b0);

    // Protocol violations, each from a clean reset.
    do_reset();
    pop_valid = 1'b1;
    pop_bank  = 3'd2;
    tick();
    chk("pop_free/error", 32'(error), 32'd1);
    do_reset();
    chk("rst_clears/error", 32'(error), 32'd0);
    push_port = 5'b00100;
    tick();
    chk_out("push_noown", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b1);
    do_reset();
    release_port = 5'b01000;
    tick();
    chk_out("rel_noown", 5'b00000, 3'd0, 5'b00000, 1'b0, 3'd6, 1'b1);
    do_reset();
    req_port = 5'b00001;
    tick();
    req_port  = 5'b00000;
    pop_valid = 1'b1;
    pop_bank  = 3'd0;
    tick();
    chk_out("pop_empty", 5'b00000, 3'd0, 5'b00001, 1'b0, 3'd5, 1'b1);
    pop_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
